alu_4bit_bist: RTL and testbench

ALU_4BIT_BIST -- requirements
Module: alu_4bit_bist

---
 rtl/alu_4bit_pkg.sv | 22 ++
 rtl/alu_4bit_model.sv | 24 ++
 rtl/alu_4bit_bist.sv | 120 ++++++++++++
 tb/tb_alu_4bit_bist.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_4bit_pkg.sv
// Shared constants and types for the 4-bit ALU built-in self test.
// Op-select encodings, sweep size and controller state type.
package alu_4bit_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    localparam int          VEC_COUNT = 1024;
    localparam logic [9:0]  LAST_VEC  = 10'(VEC_COUNT - 1);
    localparam logic [10:0] ERR_MAX   = 11'(VEC_COUNT);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/alu_4bit_model.sv
// Combinational reference model of the 4-bit ALU.
// Produces the 8-bit result expected for operands a, b and select s.
module alu_4bit_model
    import alu_4bit_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] s,
    output logic [7:0] f
);

    // Select the expected result; subtraction wraps in 8-bit two's complement
    always_comb begin
        f = 8'h00;
        unique case (s)
            OP_ADD:  f = {4'h0, a} + {4'h0, b};
            OP_SUB:  f = {4'h0, a} - {4'h0, b};
            OP_MUL:  f = {4'h0, a} * {4'h0, b};
            OP_AND:  f = {4'h0, a & b};
            default: f = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_4bit_bist.sv
// Exhaustive self-test controller for a 4-bit ALU.
// Sweeps all {s,a,b} vectors, compares f_in and reports errors.
module alu_4bit_bist
    import alu_4bit_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  f_in,
    output logic [3:0]  a_out,
    output logic [3:0]  b_out,
    output logic [1:0]  s_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [10:0] err_count,
    output logic [9:0]  first_fail
);

    localparam logic [3:0] WAIT_LAST = 4'(SETTLE_CYCLES - 2);

    state_t      state;
    state_t      state_nxt;
    logic [9:0]  vec;
    logic [3:0]  wcnt;
    logic [7:0]  expected;
    logic        mismatch;

    assign s_out = vec[9:8];
    assign a_out = vec[7:4];
    assign b_out = vec[3:0];

    alu_4bit_model u_model (
        .a (a_out),
        .b (b_out),
        .s (s_out),
        .f (expected)
    );

    assign mismatch = (f_in != expected);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and status decode
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = DRIVE;
            end
            DRIVE: begin
                busy      = 1'b1;
                state_nxt = (SETTLE_CYCLES > 1) ? WAIT : CHECK;
            end
            WAIT: begin
                busy = 1'b1;
                if (wcnt == WAIT_LAST) state_nxt = CHECK;
            end
            CHECK: begin
                busy      = 1'b1;
                state_nxt = (vec == LAST_VEC) ? DONE : DRIVE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Vector index, settle counter and result bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vec        <= '0;
            wcnt       <= '0;
            err_count  <= '0;
            first_fail <= '0;
            pass       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        vec        <= '0;
                        err_count  <= '0;
                        first_fail <= '0;
                        pass       <= 1'b0;
                    end
                end
                DRIVE: begin
                    wcnt <= '0;
                end
                WAIT: begin
                    wcnt <= wcnt + 4'd1;
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_count != ERR_MAX)
                            err_count <= err_count + 11'd1;
                        if (err_count == '0)
                            first_fail <= vec;
                    end
                    if (vec != LAST_VEC) vec <= vec + 10'd1;
                end
                DONE: begin
                    pass <= (err_count == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_4bit_bist.sv
// Directed bench for alu_4bit_bist with a golden and faulty ALU.
// Two instances cover settle times of one and three cycles.
module tb_alu_4bit_bist;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1, start3;
    logic [7:0]  f1, f3;
    logic [3:0]  a1, b1, a3, b3;
    logic [1:0]  s1, s3;
    logic        busy1, done1, pass1;
    logic        busy3, done3, pass3;
    logic [10:0] err1, err3;
    logic [9:0]  ff1, ff3;
    int          mode;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] gold(logic [1:0] s, logic [3:0] a, logic [3:0] b);
        int r;
        case (s)
            2'd0:    r = int'(a) + int'(b);
            2'd1:    r = int'(a) - int'(b);
            2'd2:    r = int'(a) * int'(b);
            default: r = int'(a & b);
        endcase
        return r[7:0];
    endfunction

    function automatic logic [7:0] alu_f(int m, logic [9:0] v);
        logic [7:0] g;
        g = gold(v[9:8], v[7:4], v[3:0]);
        case (m)
            1:       return g | 8'h01;
            2:       return (v == 10'h1A5) ? (g ^ 8'h80) : g;
            3:       return (v == 10'h144) ? (g ^ 8'h01) : g;
            default: return g;
        endcase
    endfunction

    assign f1 = alu_f(mode, {s1, a1, b1});
    assign f3 = gold(s3, a3, b3);

    alu_4bit_bist #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .f_in(f1),
        .a_out(a1), .b_out(b1), .s_out(s1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail(ff1)
    );

    alu_4bit_bist #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .f_in(f3),
        .a_out(a3), .b_out(b3), .s_out(s3),
        .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_fail(ff3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic get_done(int w);
        return (w == 3) ? done3 : done1;
    endfunction

    function automatic logic get_busy(int w);
        return (w == 3) ? busy3 : busy1;
    endfunction

    function automatic logic get_pass(int w);
        return (w == 3) ? pass3 : pass1;
    endfunction

    function automatic logic [9:0] get_vec(int w);
        return (w == 3) ? {s3, a3, b3} : {s1, a1, b1};
    endfunction

    task automatic set_start(input int w, input logic v);
        if (w == 3) start3 = v;
        else        start1 = v;
    endtask

    // Launch one sweep and follow it to completion.
    task automatic sweep(input int w, input bit spam,
                         output int cyc, output int extra, output int holdbad);
        int         run;
        int         per;
        logic [9:0] prev;
        per     = (w == 3) ? 4 : 2;
        cyc     = 0;
        extra   = 0;
        holdbad = 0;
        @(negedge clk);
        set_start(w, 1'b1);
        @(negedge clk);
        if (!spam) set_start(w, 1'b0);
        check("busy_on", get_busy(w), 1);
        check("pass_clr", get_pass(w), 0);
        prev = get_vec(w);
        run  = 1;
        while (cyc < 5000 && !get_done(w)) begin
            @(negedge clk);
            cyc++;
            if (spam) set_start(w, (cyc % 3) == 0);
            if (get_vec(w) != prev) begin
                if (run != per) holdbad++;
                run  = 1;
                prev = get_vec(w);
            end else begin
                run++;
            end
        end
        check("done_seen", get_done(w), 1);
        set_start(w, spam);
        @(negedge clk);
        set_start(w, 1'b0);
        repeat (20) begin
            @(negedge clk);
            if (get_done(w)) extra++;
        end
        check("idle_after", get_busy(w), 0);
    endtask

    initial begin
        int         cyc, extra, hb, n, stuck_exp;
        logic [7:0] g;
        logic [9:0] vv;

        stuck_exp = 0;
        for (int v = 0; v < 1024; v++) begin
            vv = v[9:0];
            g  = gold(vv[9:8], vv[7:4], vv[3:0]);
            if (g[0] == 1'b0) stuck_exp++;
        end

        rst_n  = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        mode   = 0;
        repeat (3) @(negedge clk);
        check("rst_a", a1, 0);
        check("rst_b", b1, 0);
        check("rst_s", s1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_pass", pass1, 0);
        check("rst_err", err1, 0);
        check("rst_ff", ff1, 0);
        rst_n = 1'b1;
        @(negedge clk);

        sweep(1, 1'b0, cyc, extra, hb);
        check("gold_cyc", cyc, 2048);
        check("gold_extra", extra, 0);
        check("gold_hold", hb, 0);
        check("gold_pass", pass1, 1);
        check("gold_err", err1, 0);
        check("gold_vec_held", {s1, a1, b1}, 10'h3FF);

        sweep(1, 1'b1, cyc, extra, hb);
        check("spam_cyc", cyc, 2048);
        check("spam_extra", extra, 0);
        check("spam_pass", pass1, 1);

        mode = 1;
        sweep(1, 1'b0, cyc, extra, hb);
        check("stuck_err", err1, stuck_exp);
        check("stuck_ff", ff1, 10'h000);
        check("stuck_pass", pass1, 0);

        mode = 2;
        sweep(1, 1'b0, cyc, extra, hb);
        check("one_err", err1, 1);
        check("one_ff", ff1, 10'h1A5);
        check("one_pass", pass1, 0);

        mode = 3;
        sweep(1, 1'b0, cyc, extra, hb);
        check("sub_err", err1, 1);
        check("sub_ff", ff1, 10'h144);

        mode = 1;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        n = 0;
        while ({s1, a1, b1} != 10'd500 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("reach500", {s1, a1, b1}, 10'd500);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_a", a1, 0);
        check("mid_b", b1, 0);
        check("mid_s", s1, 0);
        check("mid_busy", busy1, 0);
        check("mid_done", done1, 0);
        check("mid_err", err1, 0);
        check("mid_ff", ff1, 0);
        rst_n = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (done1 || busy1) n++;
        end
        check("mid_quiet", n, 0);
        mode = 0;
        sweep(1, 1'b0, cyc, extra, hb);
        check("restart_cyc", cyc, 2048);
        check("restart_pass", pass1, 1);
        check("restart_err", err1, 0);

        sweep(3, 1'b0, cyc, extra, hb);
        check("s3_cyc", cyc, 4096);
        check("s3_hold", hb, 0);
        check("s3_extra", extra, 0);
        check("s3_pass", pass3, 1);
        check("s3_err", err3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
